// File: rtl/des_key_schedule_if.sv
// rtl/des_key_schedule_if.sv - request/subkey handshake bundle for the DES key schedule
//
// Purpose: groups the schedule request (start/decrypt/key) and the subkey
// valid/ready stream into one interface.
// Modports:
//   master : requester/consumer side - drives start, decrypt, key, subkey_ready
//   slave  : key schedule side       - drives busy, subkey_valid, subkey,
//                                      round_idx, last (and parity_err)
// Optional macro: KEY_PARITY_CHECK_EN adds the parity_err signal.

interface des_key_schedule_if;
    logic        start;
    logic        decrypt;
    logic [1:64] key;
    logic        busy;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [1:48] subkey;
    logic [3:0]  round_idx;
    logic        last;
`ifdef KEY_PARITY_CHECK_EN
    logic        parity_err;
`endif

    modport master (
        output start, decrypt, key, subkey_ready,
        input  busy, subkey_valid, subkey, round_idx, last
`ifdef KEY_PARITY_CHECK_EN
        , input parity_err
`endif
    );

    modport slave (
        input  start, decrypt, key, subkey_ready,
        output busy, subkey_valid, subkey, round_idx, last
`ifdef KEY_PARITY_CHECK_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - DES round key generator, one subkey per handshake
//
// Purpose: on start, loads C/D from PC-1(key) and streams the 16 round keys
// (PC-2 of the rotated C/D) in encrypt order K1..K16 or decrypt order K16..K1.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : des_key_schedule_if.slave (start/decrypt/key in, subkey stream out)
// Optional macro: KEY_PARITY_CHECK_EN - reject keys whose bytes lack odd parity
// and pulse parity_err for one cycle.

module des_key_schedule (
    input  logic               clk,
    input  logic               rst_n,
    des_key_schedule_if.slave  bus
);
    typedef enum logic {IDLE, GEN} state_t;

    localparam logic [6:0] PC1_TAB [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam logic [5:0] PC2_TAB [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state;
    logic [1:28] c;
    logic [1:28] d;
    logic        mode;
    logic        busy_q;
    logic        valid_q;
    logic [1:48] subkey_q;
    logic [3:0]  round_q;
    logic        last_q;

    logic [1:56] pc1_cd;
    logic [1:56] src_cd;
    logic [1:56] rot_cd;
    logic [1:48] pc2_k;
    logic [3:0]  idx_next;
    logic        mode_next;
    logic [1:0]  amt;
    logic        shift_two;
    logic        key_ok;

    function automatic logic [1:28] rotl(input logic [1:28] x, input logic [1:0] n);
        case (n)
            2'd1:    rotl = {x[2:28], x[1]};
            2'd2:    rotl = {x[3:28], x[1:2]};
            default: rotl = x;
        endcase
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] x, input logic [1:0] n);
        case (n)
            2'd1:    rotr = {x[28], x[1:27]};
            2'd2:    rotr = {x[27:28], x[1:26]};
            default: rotr = x;
        endcase
    endfunction

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign pc1_cd[g+1] = bus.key[PC1_TAB[g]];
    end

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign pc2_k[g+1] = rot_cd[PC2_TAB[g]];
    end

`ifdef KEY_PARITY_CHECK_EN
    logic [7:0] byte_odd;
    logic       parity_err_q;

    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_odd[b] = ^bus.key[8*b+1 +: 8];
    end
    assign key_ok         = &byte_odd;
    assign bus.parity_err = parity_err_q;
`else
    logic unused_parity_bits;
    assign unused_parity_bits = ^{bus.key[8], bus.key[16], bus.key[24], bus.key[32],
                                  bus.key[40], bus.key[48], bus.key[56], bus.key[64]};
    assign key_ok = 1'b1;
`endif

    // The same rotate/PC-2 path serves both the start load (from PC-1) and each
    // advance (from the held C/D). Decrypt round 0 rotates by zero because the
    // 28 encrypt shifts bring C16/D16 back to C0/D0; later decrypt rounds undo
    // the encrypt shifts in reverse, which yields the same 1,2..2,1 pattern.
    always_comb begin
        src_cd    = {c, d};
        idx_next  = round_q + 4'd1;
        mode_next = mode;
        if (state == IDLE) begin
            src_cd    = pc1_cd;
            idx_next  = 4'd0;
            mode_next = bus.decrypt;
        end
        shift_two = !((idx_next == 4'd0) || (idx_next == 4'd1) ||
                      (idx_next == 4'd8) || (idx_next == 4'd15));
        amt = shift_two ? 2'd2 : 2'd1;
        if (mode_next && (idx_next == 4'd0))
            amt = 2'd0;
        if (mode_next)
            rot_cd = {rotr(src_cd[1:28], amt), rotr(src_cd[29:56], amt)};
        else
            rot_cd = {rotl(src_cd[1:28], amt), rotl(src_cd[29:56], amt)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            c        <= '0;
            d        <= '0;
            mode     <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            subkey_q <= '0;
            round_q  <= 4'd0;
            last_q   <= 1'b0;
`ifdef KEY_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
`ifdef KEY_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (key_ok) begin
                            state    <= GEN;
                            c        <= rot_cd[1:28];
                            d        <= rot_cd[29:56];
                            mode     <= bus.decrypt;
                            subkey_q <= pc2_k;
                            round_q  <= 4'd0;
                            last_q   <= 1'b0;
                            busy_q   <= 1'b1;
                            valid_q  <= 1'b1;
                        end
`ifdef KEY_PARITY_CHECK_EN
                        else begin
                            parity_err_q <= 1'b1;
                        end
`endif
                    end
                end
                GEN: begin
                    // subkey_valid is always 1 in GEN, so ready alone completes a transfer
                    if (bus.subkey_ready) begin
                        if (round_q == 4'd15) begin
                            state    <= IDLE;
                            busy_q   <= 1'b0;
                            valid_q  <= 1'b0;
                            subkey_q <= '0;
                            round_q  <= 4'd0;
                            last_q   <= 1'b0;
                        end else begin
                            c        <= rot_cd[1:28];
                            d        <= rot_cd[29:56];
                            subkey_q <= pc2_k;
                            round_q  <= idx_next;
                            last_q   <= (idx_next == 4'd15);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.subkey_valid = valid_q;
    assign bus.subkey       = subkey_q;
    assign bus.round_idx    = round_q;
    assign bus.last         = last_q;
endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - directed self-checking bench for des_key_schedule
module tb_des_key_schedule;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_key_schedule_if bus();

    des_key_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [63:0] KEY_STD  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_WEAK = 64'h0101010101010101;

    localparam logic [47:0] ENC_KEYS [0:15] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    int n_checks = 0;
    int n_pass   = 0;

    logic [47:0] got [0:15];
    int          got_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a schedule and collects the 16 subkeys. The key/decrypt inputs are
    // corrupted right after the start cycle; poke keeps start asserted with a
    // different key for the whole run, including the final handshake.
    task automatic run(input logic [63:0] k, input logic dec, input bit rnd_ready, input bit poke);
        logic [47:0] held;
        logic [3:0]  held_idx;
        bit          held_v;
        int          guard;
        bus.key          = k;
        bus.decrypt      = dec;
        bus.start        = 1'b1;
        bus.subkey_ready = 1'b0;
        tick();
        bus.start   = poke;
        bus.key     = KEY_WEAK ^ {32'h0, $urandom};
        bus.decrypt = ~dec;
        check("first_valid", bus.subkey_valid, 1);
        check("first_busy", bus.busy, 1);
`ifdef KEY_PARITY_CHECK_EN
        check("parity_ok", bus.parity_err, 0);
`endif
        got_n  = 0;
        held_v = 0;
        guard  = 0;
        while (got_n < 16 && guard < 400) begin
            if (bus.subkey_valid) begin
                if (held_v) check("stall_hold", {bus.round_idx, bus.subkey}, {held_idx, held});
                check("round_idx", bus.round_idx, got_n);
                check("last", bus.last, got_n == 15);
                bus.subkey_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.subkey_ready) begin
                    got[got_n] = bus.subkey;
                    got_n++;
                    held_v = 0;
                end else begin
                    held_v   = 1;
                    held     = bus.subkey;
                    held_idx = bus.round_idx;
                end
            end else begin
                check("valid_gap", bus.subkey_valid, 1);
            end
            tick();
            guard++;
        end
        check("key_count", got_n, 16);
        check("done_busy", bus.busy, 0);
        check("done_valid", bus.subkey_valid, 0);
        check("done_subkey", bus.subkey, 0);
        bus.start        = 1'b0;
        bus.subkey_ready = 1'b0;
        tick();
        check("stay_idle", bus.busy, 0);
    endtask

    initial begin
        int guard;
        bus.start        = 1'b0;
        bus.decrypt      = 1'b0;
        bus.key          = '0;
        bus.subkey_ready = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.subkey_valid, 0);
        check("rst_subkey", bus.subkey, 0);
        check("rst_idx", bus.round_idx, 0);
        check("rst_last", bus.last, 0);
`ifdef KEY_PARITY_CHECK_EN
        check("rst_perr", bus.parity_err, 0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // encrypt order, full throughput
        run(KEY_STD, 1'b0, 0, 0);
        for (int i = 0; i < 16; i++) check($sformatf("enc_k%0d", i + 1), got[i], ENC_KEYS[i]);

        // decrypt order is the encrypt sequence reversed
        run(KEY_STD, 1'b1, 0, 0);
        for (int i = 0; i < 16; i++) check($sformatf("dec_r%0d", i), got[i], ENC_KEYS[15 - i]);

        // weak key, random backpressure
        run(KEY_WEAK, 1'b0, 1, 0);
        for (int i = 0; i < 16; i++) check($sformatf("weak_r%0d", i), got[i], 0);

        // start held high through GEN and the final handshake is ignored
        run(KEY_STD, 1'b0, 0, 1);
        for (int i = 0; i < 16; i++) check($sformatf("poke_k%0d", i + 1), got[i], ENC_KEYS[i]);

        // reset at round 7
        bus.key          = KEY_STD;
        bus.decrypt      = 1'b0;
        bus.start        = 1'b1;
        bus.subkey_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        guard = 0;
        while (bus.round_idx != 4'd7 && guard < 40) begin
            tick();
            guard++;
        end
        check("reach_r7", bus.round_idx, 7);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", bus.busy, 0);
        check("mrst_valid", bus.subkey_valid, 0);
        check("mrst_subkey", bus.subkey, 0);
        check("mrst_idx", bus.round_idx, 0);
        check("mrst_last", bus.last, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_idle", {bus.busy, bus.subkey_valid}, 0);
        end

        // start accepted at the first edge after reset release
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("rel_valid", bus.subkey_valid, 1);
        check("rel_k1", bus.subkey, ENC_KEYS[0]);
        for (int i = 0; i < 16; i++) tick();
        check("rel_done", bus.busy, 0);

`ifdef KEY_PARITY_CHECK_EN
        bus.subkey_ready = 1'b0;
        bus.key          = 64'h0;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        check("perr_pulse", bus.parity_err, 1);
        check("perr_busy", bus.busy, 0);
        check("perr_valid", bus.subkey_valid, 0);
        tick();
        check("perr_clear", bus.parity_err, 0);
        check("perr_idle", bus.busy, 0);
        run(KEY_STD, 1'b0, 0, 0);
        check("perr_run_k16", got[15], ENC_KEYS[15]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 Parameters: none; all widths fixed by the DES standard.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a new schedule; sampled only when busy=0.
REQ-005 decrypt  input  1  0: emit K1..K16 (encrypt order); 1: emit K16..K1 (decrypt order); sampled with start.
REQ-006 key  input  [1:64]  DES key, bit 1 = MSB, bits 8,16,..,64 are parity bits; sampled with start.
REQ-007 busy  output  1  schedule in progress.
REQ-008 subkey_valid  output  1  subkey holds a valid round key.
REQ-009 subkey_ready  input  1  consumer accepts subkey; transfer when valid and ready are both 1.
REQ-010 subkey  output  [1:48]  round key, PC-2 ordering, bit 1 = MSB.
REQ-011 round_idx  output  4  index of the presented subkey in emission order, 0..15.
REQ-012 last  output  1  high with subkey_valid when round_idx=15.
REQ-013 parity_err  output  1  present only with KEY_PARITY_CHECK_EN (see REQ-031).

Function
REQ-014 States: IDLE, GEN. IDLE: busy=0, subkey_valid=0.
- IDLE->GEN: start=1 in cycle N.
- Latch C,D = PC-1(key) (28 bits each).
- Latch mode from decrypt.
REQ-015 Encrypt left-rotation amounts before rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-016 Decrypt right-rotation amounts before rounds 1..16: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; no rotation before the first decrypt key, since 28 total shifts restore C0D0.
REQ-017 subkey = PC-2(C,D) after the rotation for the current round; C and D rotate independently.
REQ-018 First subkey_valid=1 in cycle N+1 with round_idx=0.
REQ-019 On each handshake, the next round is presented in the following cycle (one key per cycle at full throughput).
REQ-020 While subkey_valid=1 and subkey_ready=0, subkey, round_idx and last hold stable.
REQ-021 Handshake at round_idx=15: next cycle subkey_valid=0, busy=0, return to IDLE.
REQ-022 start while busy=1 is ignored, including in the cycle of the final handshake; no queuing.
REQ-023 key/decrypt changes after the start cycle have no effect on the running schedule.
REQ-024 round_idx wraps to 0 only through a new start; it never exceeds 15.
REQ-025 subkey is driven 0 whenever subkey_valid=0.

Reset
REQ-026 rst_n=0 immediately forces:
- IDLE, busy=0, subkey_valid=0, subkey=0, round_idx=0, last=0, parity_err=0.
- C=D=0, mode=0.
REQ-027 Reset mid-schedule abandons the schedule with no further subkeys; after release the block waits for a new start.
REQ-028 The first start is accepted in the first clk edge with rst_n=1.

Configuration
REQ-029 Macro KEY_PARITY_CHECK_EN controls key parity checking.
REQ-030 Without KEY_PARITY_CHECK_EN: parity bits are ignored, the parity_err port is absent, and every start is accepted.
REQ-031 With KEY_PARITY_CHECK_EN: on start in IDLE, each key byte must have odd parity.
- On any failure: block stays IDLE, busy=0, no subkeys.
- parity_err=1 for exactly the cycle after start.
- Otherwise parity_err=0.

Verification
REQ-032 key=133457799BBCDFF1, decrypt=0, ready=1 -> 16 consecutive valids; round 0 = 1B02EFFC7072, round 15 = CB3D8B0E17F5 with last=1; busy=0 one cycle later.
REQ-033 Same key, decrypt=1 -> round 0 = CB3D8B0E17F5, round 15 = 1B02EFFC7072; full sequence equals the encrypt sequence reversed.
REQ-034 key=0101010101010101 with ready toggled pseudo-randomly -> all 16 subkeys = 000000000000, values stable across stalls, round_idx 0..15 without gaps.
REQ-035 rst_n=0 at round_idx=7, start pulsed during GEN and at the final handshake -> outputs zero at once, no extra subkeys, start ignored while busy.
REQ-036 With KEY_PARITY_CHECK_EN, key=0000000000000000 -> parity_err pulses 1 cycle, busy stays 0; key=133457799BBCDFF1 -> parity_err=0, schedule runs.
